// File: rtl/a2d_pkg.sv
// a2d_pkg: shared scan-state encoding and SPI command framing for the A2D scanner
package a2d_pkg;

    typedef enum logic [2:0] {IDLE, SEL, CMD1, GAP, CMD2, STORE} a2d_scan_state_t;

    localparam logic [1:0] A2D_CMD_PREFIX = 2'b00;

    function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
        return {A2D_CMD_PREFIX, ch, 11'h000};
    endfunction

endpackage

// File: rtl/SPI_mstr16.sv
// SPI_mstr16: 16-bit mode-0 SPI master, SCLK = clk/4, MSB first, one-cycle done pulse
module SPI_mstr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    logic        act_q;
    logic [1:0]  div_q;
    logic [3:0]  bit_q;
    logic [15:0] shft_q;
    logic        miso_q;
    logic        done_q;

    // Frame sequencer: sample MISO as SCLK rises, shift as SCLK falls, finish after 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= 1'b0;
            div_q  <= 2'd0;
            bit_q  <= 4'd0;
            shft_q <= 16'h0000;
            miso_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!act_q) begin
                if (wrt) begin
                    act_q  <= 1'b1;
                    div_q  <= 2'd0;
                    bit_q  <= 4'd0;
                    shft_q <= cmd;
                end
            end else begin
                div_q <= div_q + 2'd1;
                if (div_q == 2'd1)
                    miso_q <= MISO;
                if (div_q == 2'd3) begin
                    shft_q <= {shft_q[14:0], miso_q};
                    bit_q  <= bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        act_q  <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign SS_n    = ~act_q;
    assign SCLK    = act_q & div_q[1];
    assign MOSI    = shft_q[15];
    assign done    = done_q;
    assign rd_data = shft_q;

endmodule

// File: rtl/a2d_scan_intf.sv
// a2d_scan_intf: scans enabled A2D channels over SPI (two reads per channel) into a result flop array
module a2d_scan_intf
    import a2d_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int RES_W  = 12,
    parameter int INVERT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strt_cnv,
    input  logic              auto_en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [2:0]        rd_ch,
    output logic [RES_W-1:0]  rd_res,
    output logic              cnv_cmplt,
    output logic              busy,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    a2d_scan_state_t   state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [NUM_CH-1:0] scan_mask_q, scan_mask_d;
    logic              cmplt_q, cmplt_d;
    logic [RES_W-1:0]  res_q [NUM_CH];
    logic              wrt, done, store, found;
    logic [2:0]        sel_idx;
    logic [15:0]       rd_data;
    logic [RES_W-1:0]  res_val;
    logic              unused_bits;

    SPI_mstr16 u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (a2d_cmd(state_q == SEL ? sel_idx : ptr_q)),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    assign res_val     = (INVERT != 0) ? ~rd_data[11 -: RES_W] : rd_data[11 -: RES_W];
    assign unused_bits = ^rd_data[15:12];

    // Lowest still-pending channel at or above the pointer
    always_comb begin
        found   = 1'b0;
        sel_idx = ptr_q;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (scan_mask_q[i] && 3'(i) >= ptr_q) begin
                found   = 1'b1;
                sel_idx = 3'(i);
            end
    end

    // Scan sequencer: next state, pointer, pending mask, completion flag and SPI strobes
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        scan_mask_d = scan_mask_q;
        cmplt_d     = cmplt_q;
        wrt         = 1'b0;
        store       = 1'b0;
        unique case (state_q)
            IDLE:
                if (strt_cnv || auto_en) begin
                    state_d     = SEL;
                    scan_mask_d = ch_mask;
                    ptr_d       = 3'd0;
                    cmplt_d     = 1'b0;
                end
            SEL:
                if (found) begin
                    ptr_d   = sel_idx;
                    wrt     = 1'b1;
                    state_d = CMD1;
                end else begin
                    state_d = IDLE;
                    cmplt_d = 1'b1;
                end
            CMD1: if (done) state_d = GAP;
            GAP: begin
                wrt     = 1'b1;
                state_d = CMD2;
            end
            CMD2: if (done) state_d = STORE;
            STORE: begin
                store       = 1'b1;
                scan_mask_d = scan_mask_q & ~(NUM_CH'(1) << ptr_q);
                state_d     = SEL;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            scan_mask_q <= '0;
            cmplt_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            scan_mask_q <= scan_mask_d;
            cmplt_q     <= cmplt_d;
        end
    end

    // Result array: only the channel just read is overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (store && ptr_q == 3'(i)) res_q[i] <= res_val;
        end
    end

    // Read port: out-of-range channels read as zero
    always_comb begin
        rd_res = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (rd_ch == 3'(i)) rd_res = res_q[i];
    end

    assign busy      = (state_q != IDLE);
    assign cnv_cmplt = cmplt_q;

endmodule

// File: tb/tb_a2d_scan_intf.sv
// tb_a2d_scan_intf: SPI slave models, scan-level reference model and directed scenarios
module tb_a2d_scan_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        strt_cnv = 1'b0, auto_en = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [2:0]  rd_ch = 3'd0;
    logic [11:0] rd_res;
    logic        cnv_cmplt, busy, ss_n, sclk, mosi, miso;

    logic        strt2 = 1'b0;
    logic [3:0]  mask2 = 4'h0;
    logic [2:0]  rd_ch2 = 3'd0;
    logic [7:0]  rd_res2;
    logic        cmplt2, busy2, ss2, sclk2, mosi2, miso2;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    a2d_scan_intf dut (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .auto_en(auto_en), .ch_mask(ch_mask),
        .rd_ch(rd_ch), .rd_res(rd_res), .cnv_cmplt(cnv_cmplt), .busy(busy),
        .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    a2d_scan_intf #(.NUM_CH(4), .RES_W(8), .INVERT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt2), .auto_en(1'b0), .ch_mask(mask2),
        .rd_ch(rd_ch2), .rd_res(rd_res2), .cnv_cmplt(cmplt2), .busy(busy2),
        .SS_n(ss2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI slave for the main DUT: shifts out resp1, captures each 16-bit command
    logic [15:0] resp1 = 16'hF123, s_tx = 16'h0000, s_rx = 16'h0000;
    logic [15:0] rx_q[$], log_q[$];
    int          nrise = 16;

    always @(ss_n or posedge sclk) begin
        if (ss_n === 1'b1) begin
            rx_q.push_back(s_rx);
            log_q.push_back(s_rx);
        end else if (ss_n === 1'b0 && sclk === 1'b1) begin
            s_rx = {s_rx[14:0], mosi};
            nrise++;
        end else if (ss_n === 1'b0) begin
            s_tx  = resp1;
            nrise = 0;
        end
    end
    assign miso = (nrise < 16) ? s_tx[4'(15 - nrise)] : 1'b0;

    // SPI slave for the narrow DUT: always answers 16'h0ABC
    logic [15:0] tx2 = 16'h0ABC;
    int          nrise2 = 16;

    always @(ss2 or posedge sclk2) begin
        if (ss2 === 1'b0 && sclk2 === 1'b1) nrise2++;
        else if (ss2 === 1'b0) nrise2 = 0;
    end
    assign miso2 = (nrise2 < 16) ? tx2[4'(15 - nrise2)] : 1'b0;

    function automatic logic [15:0] lq(input int i);
        return (i < log_q.size()) ? log_q[i] : 16'hxxxx;
    endfunction

    // Reference model: a scan reads every enabled channel twice in ascending order,
    // then each scanned channel holds the inverted low 12 bits of the slave reply
    logic [11:0] exp_res [8];
    logic [7:0]  m_mask = 8'h00;
    logic [15:0] m_resp = 16'h0000;
    logic [15:0] m_exp[$];
    bit          prev_busy = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            foreach (exp_res[i]) exp_res[i] = 12'h000;
            rx_q.delete();
            prev_busy = 1'b0;
            chk("rst_busy", busy, 1'b0);
            chk("rst_cmplt", cnv_cmplt, 1'b0);
            chk("rst_ssn", ss_n, 1'b1);
        end else begin
            if (busy && !prev_busy) begin
                m_mask = ch_mask;
                m_resp = resp1;
            end
            if (!busy && prev_busy) begin
                m_exp.delete();
                for (int c = 0; c < 8; c++)
                    if (m_mask[c]) repeat (2) m_exp.push_back(16'(c * 2048));
                chk("scan_frames", rx_q.size(), m_exp.size());
                foreach (m_exp[i]) chk("scan_cmd", (i < rx_q.size()) ? rx_q[i] : 16'hxxxx, m_exp[i]);
                rx_q.delete();
                chk("scan_cmplt", cnv_cmplt, 1'b1);
                for (int c = 0; c < 8; c++)
                    if (m_mask[c]) exp_res[c] = ~m_resp[11:0];
            end
            if (!busy) chk("rd_res", rd_res, exp_res[rd_ch]);
            if (!ss_n) chk("busy_in_frame", busy, 1'b1);
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(negedge clk);
        rd_ch = rd_ch + 3'd1;
    endtask

    task automatic wait_cmplt(input string name);
        int n = 0;
        while (!cnv_cmplt && n < 3000) begin
            tick();
            n++;
        end
        chk(name, cnv_cmplt, 1'b1);
    endtask

    task automatic start(input logic [7:0] m);
        ch_mask  = m;
        strt_cnv = 1'b1;
        tick();
        strt_cnv = 1'b0;
    endtask

    logic [15:0] e36 [6] = '{16'h1000, 16'h1000, 16'h2800, 16'h2800, 16'h3800, 16'h3800};
    logic [15:0] e39 [4] = '{16'h0800, 16'h0800, 16'h1000, 16'h1000};

    initial begin
        int n;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rd_ch = 3'd3; rd_ch2 = 3'd1; #1;
        chk("reset_rd_res", rd_res, 12'h000);
        chk("reset_rd_res2", rd_res2, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_cmplt", cnv_cmplt, 1'b0);
        chk("reset_ssn", ss_n, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        log_q.delete();
        start(8'h01);
        wait_cmplt("ch0_done");
        chk("ch0_frames", log_q.size(), 2);
        chk("ch0_cmd_a", lq(0), 16'h0000);
        chk("ch0_cmd_b", lq(1), 16'h0000);
        rd_ch = 3'd0; #1;
        chk("ch0_result", rd_res, 12'hEDC);
        repeat (5) tick();
        chk("ch0_cmplt_held", cnv_cmplt, 1'b1);
        chk("ch0_idle", busy, 1'b0);

        log_q.delete();
        ch_mask = 8'hA4; strt_cnv = 1'b1;
        tick();
        strt_cnv = 1'b0;
        n = 0;
        while (!cnv_cmplt && n < 5000) begin
            chk("a4_busy", busy, 1'b1);
            tick();
            n++;
        end
        chk("a4_done", cnv_cmplt, 1'b1);
        chk("a4_frames", log_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("a4_cmd", lq(i), e36[i]);
        rd_ch = 3'd5; #1; chk("a4_res5", rd_res, 12'hEDC);
        rd_ch = 3'd3; #1; chk("a4_res3_untouched", rd_res, 12'h000);
        rd_ch = 3'd0; #1; chk("a4_res0_kept", rd_res, 12'hEDC);

        log_q.delete();
        tick();
        ch_mask = 8'h00; strt_cnv = 1'b1;
        tick();
        chk("empty_busy_c1", busy, 1'b1);
        chk("empty_cmplt_c1", cnv_cmplt, 1'b0);
        tick();
        chk("empty_cmplt_c2", cnv_cmplt, 1'b1);
        chk("empty_busy_c2", busy, 1'b0);
        strt_cnv = 1'b0;
        tick();
        chk("strt_not_queued", busy, 1'b0);
        chk("empty_cmplt_held", cnv_cmplt, 1'b1);
        chk("empty_no_frames", log_q.size(), 0);

        resp1 = 16'h05A7;
        log_q.delete();
        start(8'h06);
        n = 0;
        while (log_q.size() < 1 && n < 500) begin
            tick();
            n++;
        end
        ch_mask = 8'hFF; strt_cnv = 1'b1;
        tick();
        strt_cnv = 1'b0; ch_mask = 8'h00;
        wait_cmplt("mid_done");
        chk("mid_frames", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("mid_cmd", lq(i), e39[i]);
        repeat (20) tick();
        chk("mid_no_extra_busy", busy, 1'b0);
        chk("mid_no_extra_frames", log_q.size(), 4);
        rd_ch = 3'd2; #1; chk("mid_res2", rd_res, 12'hA58);

        mask2 = 4'h2; strt2 = 1'b1;
        tick();
        strt2 = 1'b0;
        n = 0;
        while (!cmplt2 && n < 3000) begin
            tick();
            n++;
        end
        chk("narrow_done", cmplt2, 1'b1);
        rd_ch2 = 3'd1; #1; chk("narrow_res1", rd_res2, 8'hAB);
        rd_ch2 = 3'd0; #1; chk("narrow_res0", rd_res2, 8'h00);
        rd_ch2 = 3'd5; #1; chk("narrow_out_of_range", rd_res2, 8'h00);

        resp1 = 16'h3C3C;
        log_q.delete();
        ch_mask = 8'h03; auto_en = 1'b1;
        n = 0;
        while (!(log_q.size() == 7 && !ss_n) && n < 3000) begin
            tick();
            n++;
        end
        chk("auto_reach_cmd2", log_q.size(), 7);
        repeat (5) tick();
        rst_n = 1'b0;
        rd_ch = 3'd1; #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_cmplt", cnv_cmplt, 1'b0);
        chk("abort_ssn", ss_n, 1'b1);
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_res", rd_res, 12'h000);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_cmplt("resume_done");
        tick();
        chk("auto_pulse_width", cnv_cmplt, 1'b0);
        chk("auto_restarted", busy, 1'b1);
        auto_en = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk("auto_stop", busy, 1'b0);
        rd_ch = 3'd0; #1; chk("resume_res0", rd_res, 12'h3C3);
        rd_ch = 3'd1; #1; chk("resume_res1", rd_res, 12'h3C3);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a2d_scan_intf.md
A2D_SCAN_INTF -- requirements
Module: a2d_scan_intf

Interface
REQ-001 Parameter NUM_CH, default 8, number of scannable channels (legal 1..8).
REQ-002 Parameter RES_W, default 12, stored result width (legal 8..12).
REQ-003 Parameter INVERT, default 1; when 1, the raw A2D data is bit-inverted before it is stored.
REQ-004 clk  input  1  clock; all logic is rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 strt_cnv  input  1  single-cycle request to start one scan.
REQ-007 auto_en  input  1  continuous-scan enable.
REQ-008 ch_mask  input  NUM_CH  channel enables; bit i enables channel i.
REQ-009 rd_ch  input  3  read-port channel select.
REQ-010 rd_res  output  RES_W  stored result of channel rd_ch, combinational read.
REQ-011 cnv_cmplt  output  1  scan complete; held high until the next scan starts.
REQ-012 busy  output  1  high while a scan is in progress.
REQ-013 SS_n, SCLK, MOSI  output  1 each; MISO  input  1; SPI pins passed straight through to the SPI master.

Function
REQ-014 States SHALL be IDLE, SEL, CMD1, GAP, CMD2, STORE.
REQ-015 IDLE->SEL SHALL occur when strt_cnv=1 or auto_en=1. On that edge ch_mask is latched into scan_mask, the channel pointer is cleared to 0, and cnv_cmplt is cleared.
REQ-016 SEL SHALL take one cycle:
- If it finds the lowest set bit of scan_mask at index >= pointer, it loads the pointer with that index, asserts wrt in the same cycle, and moves to CMD1.
- If no such bit exists, it moves to IDLE and sets cnv_cmplt.
REQ-017 Every SPI command SHALL be {2'b00, ch[2:0], 11'h000}; ch is zero-extended when NUM_CH<8.
REQ-018 CMD1 SHALL wait for done, then move to GAP.
REQ-019 GAP SHALL last exactly one cycle, assert wrt (same command), and move to CMD2.
REQ-020 CMD2 SHALL wait for done, then move to STORE.
REQ-021 STORE SHALL capture the result in one cycle:
- Write entry[pointer] = f(rd_data[11:12-RES_W]), where f is bit-inversion if INVERT=1, identity otherwise.
- Clear scan_mask[pointer].
- Move to SEL.
REQ-022 A scan with m enabled channels SHALL produce exactly 2m SPI transactions, in ascending channel order.
REQ-023 A scan with scan_mask==0 SHALL set cnv_cmplt 2 cycles after strt_cnv with zero SPI traffic.
REQ-024 strt_cnv SHALL be ignored while busy=1. ch_mask changes during a scan SHALL NOT affect that scan.
REQ-025 With auto_en=1, IDLE SHALL immediately restart a new scan. The cnv_cmplt pulse from the completed scan SHALL last exactly one cycle.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 Result entries not written by a scan SHALL keep their previous value.
REQ-028 rd_ch >= NUM_CH SHALL return 0.
REQ-029 When strt_cnv and the completion of SEL occur on the same cycle, SEL-completion takes effect. The strt_cnv is not queued.

Reset
REQ-030 While rst_n is asserted, state=IDLE, pointer=0, scan_mask=0, all result entries=0, cnv_cmplt=0, busy=0.
REQ-031 Reset mid-scan SHALL abort immediately and discard the partial result. The SPI master is reset by the same rst_n, so SS_n returns high.

Structure
REQ-032 Package a2d_pkg SHALL hold the state enum a2d_scan_state_t and the constant A2D_CMD_PREFIX=2'b00.
REQ-033 Exactly one sub-module SHALL exist: SPI_mstr16 (16-bit SPI master with cmd/wrt/done/rd_data), instantiated once.
REQ-034 Result storage SHALL be a NUM_CH x RES_W flop array with no RAM macro.

Verification
REQ-035 Reset, then strt_cnv with ch_mask=8'h01 and MISO model returning 16'hF123 -> 2 transactions, cmd 16'h0000; rd_res(ch0)=12'hEDC; cnv_cmplt=1 and held.
REQ-036 ch_mask=8'hA4 -> commands for ch2, ch5, ch7, each sent twice, in that order; busy high throughout; 6 SS_n frames.
REQ-037 ch_mask=0, strt_cnv -> cnv_cmplt=1 two cycles later; SS_n stays high.
REQ-038 RES_W=8, INVERT=0, model returns 16'h0ABC -> rd_res=8'hAB.
REQ-039 Mid-scan: toggle ch_mask and pulse strt_cnv -> scan order is unchanged; no extra scan occurs.
REQ-040 auto_en=1 with ch_mask=8'h03, then assert rst_n during the second CMD2 -> all outputs return to their reset values; scanning resumes after release.
